// File: rtl/lbcnn_pkg.sv
// Shared definitions for the LBC network datapath.
//   DATA_W : width of every feature / activation word
//   data_t : signed feature word, shared with fc_layer
//   relu   : optional rectifier applied to a single word
package lbcnn_pkg;

   localparam int DATA_W = 16;

   typedef logic signed [DATA_W-1:0] data_t;

   // Negative words become zero when the rectifier is enabled.
   function automatic data_t relu(input data_t d, input logic en);
      return (en && (d < 0)) ? data_t'(0) : d;
   endfunction

endpackage

// File: rtl/fc_feature_collector_if.sv
// Bundle of the collector's stream-in and vector-out signals.
//   s_valid/s_ready/s_data/s_last : sample stream from the conv/pool path
//   m_valid/m_ack/m_inputs        : assembled vector toward fc_layer
//   err_len                       : framing error pulse
// slave  = collector side, master = producer/consumer side.
interface fc_feature_collector_if import lbcnn_pkg::*; #(
   parameter int VEC_LEN = 64
);
   logic  s_valid;
   logic  s_ready;
   data_t s_data;
   logic  s_last;
   logic  m_valid;
   logic  m_ack;
   data_t m_inputs [0:VEC_LEN-1];
   logic  err_len;

   modport slave (
      input  s_valid, s_data, s_last, m_ack,
      output s_ready, m_valid, m_inputs, err_len
   );

   modport master (
      output s_valid, s_data, s_last, m_ack,
      input  s_ready, m_valid, m_inputs, err_len
   );
endinterface

// File: rtl/fc_vec_bank.sv
// One vector bank: VEC_LEN registered words written one at a time,
// read out all at once.
//   clk, rst : clock, asynchronous active-high clear to zero
//   we       : write strobe
//   idx      : word index to write
//   din      : word to write
//   dout     : the whole bank, word k at dout[k]
module fc_vec_bank import lbcnn_pkg::*; #(
   parameter int VEC_LEN = 64,
   parameter int IDX_W   = $clog2(VEC_LEN)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [IDX_W-1:0]     idx,
   input  data_t                din,
   output data_t [VEC_LEN-1:0]  dout
);

   data_t [VEC_LEN-1:0] mem_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_reg <= '0;
      end else if (we) begin
         mem_reg[idx] <= din;
      end
   end

   for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_out
      assign dout[gi] = mem_reg[gi];
   end

endmodule

// File: rtl/fc_feature_collector.sv
// Assembles a stream of signed feature samples into a flattened vector of
// IP_LAYER*NUM_INP words for fc_layer, using two ping-pong banks so one
// vector is presented while the next fills. Optional ReLU on ingress and
// a framing check on s_last.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fc_feature_collector_if (stream in, vector out,
//              err_len pulse)
module fc_feature_collector import lbcnn_pkg::*; #(
   parameter int IP_LAYER = 8,
   parameter int NUM_INP  = 8,
   parameter int RELU_EN  = 1
) (
   input logic                    clk,
   input logic                    rst,
   fc_feature_collector_if.slave  bus
);

   localparam int VEC_LEN = IP_LAYER * NUM_INP;
   localparam int IDX_W   = $clog2(VEC_LEN);

   logic             wr_bank_reg, wr_bank_next;
   logic             rd_bank_reg, rd_bank_next;
   logic [1:0]       full_reg, full_next;
   logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
   logic             err_len_reg, err_len_next;

   logic             beat_acc;
   logic             ack_fire;
   logic             at_end;
   data_t            store_data;
   data_t [VEC_LEN-1:0] bank_q [2];

   // Both flags come from registers only, so neither input handshake has a
   // combinational path to them.
   assign bus.s_ready = ~full_reg[wr_bank_reg];
   assign bus.m_valid = full_reg[rd_bank_reg];
   assign bus.err_len = err_len_reg;

   assign beat_acc   = bus.s_valid && !full_reg[wr_bank_reg];
   assign ack_fire   = bus.m_ack && full_reg[rd_bank_reg];
   assign at_end     = (wr_idx_reg == IDX_W'(VEC_LEN - 1));
   assign store_data = relu(bus.s_data, RELU_EN != 0);

   // A bank that is full is never the write target, so data beats cannot
   // disturb the vector being presented.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      fc_vec_bank #(
         .VEC_LEN (VEC_LEN),
         .IDX_W   (IDX_W)
      ) u_bank (
         .clk  (clk),
         .rst  (rst),
         .we   (beat_acc && (wr_bank_reg == 1'(gi))),
         .idx  (wr_idx_reg),
         .din  (store_data),
         .dout (bank_q[gi])
      );
   end

   for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_mux
      assign bus.m_inputs[gi] = bank_q[rd_bank_reg][gi];
   end

   always_comb begin
      wr_bank_next = wr_bank_reg;
      rd_bank_next = rd_bank_reg;
      full_next    = full_reg;
      wr_idx_next  = wr_idx_reg;
      err_len_next = 1'b0;

      if (beat_acc) begin
         if (at_end) begin
            // Vector complete; delivered even when s_last is missing.
            full_next[wr_bank_reg] = 1'b1;
            wr_bank_next           = ~wr_bank_reg;
            wr_idx_next            = '0;
            err_len_next           = ~bus.s_last;
         end else if (bus.s_last) begin
            // Early s_last: drop the partial vector, refill the same bank.
            wr_idx_next  = '0;
            err_len_next = 1'b1;
         end else begin
            wr_idx_next = IDX_W'(wr_idx_reg + 1'b1);
         end
      end

      // The ack targets a full bank and a write targets an empty one, so the
      // two updates never collide on the same flag.
      if (ack_fire) begin
         full_next[rd_bank_reg] = 1'b0;
         rd_bank_next           = ~rd_bank_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank_reg <= 1'b0;
         rd_bank_reg <= 1'b0;
         full_reg    <= 2'b00;
         wr_idx_reg  <= '0;
         err_len_reg <= 1'b0;
      end else begin
         wr_bank_reg <= wr_bank_next;
         rd_bank_reg <= rd_bank_next;
         full_reg    <= full_next;
         wr_idx_reg  <= wr_idx_next;
         err_len_reg <= err_len_next;
      end
   end

endmodule
